dbg_bus_master: RTL and testbench

//  Initiator end of the debug control bus (dbg_a/dbg_di/dbg_do/dbg_we/dbg_rd/dbg_ready).

---
 rtl/dbg_bus_pkg.sv | 12 +
 rtl/dbg_bus_wdog.sv | 24 ++
 rtl/dbg_bus_master.sv | 133 +++++++++++++
 tb/tb_dbg_bus_master.sv | 261 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/dbg_bus_pkg.sv
// Shared opcodes, response codes and FSM encoding for the debug bus master.
package dbg_bus_pkg;
    localparam logic [7:0] OP_WRITE = 8'h01;
    localparam logic [7:0] OP_READ  = 8'h02;
    localparam logic [7:0] RSP_ACK  = 8'hA5;
    localparam logic [7:0] RSP_ERR  = 8'hEE;
    localparam logic [7:0] RSP_NAK  = 8'h3F;

    typedef enum logic [2:0] {
        S_IDLE, S_ADDR, S_DHI, S_DLO, S_BUS, S_RSP1, S_RSP2
    } state_t;
endpackage

// File: rtl/dbg_bus_wdog.sv
// Bus watchdog: counts strobe cycles without ready, flags the last allowed one.
module dbg_bus_wdog #(
    parameter int TIMEOUT_W = 10
) (
    input  logic clk,
    input  logic rst,
    input  logic clr_i,
    input  logic en_i,
    output logic expired_o
);
    localparam logic [TIMEOUT_W-1:0] LAST = {{(TIMEOUT_W-1){1'b1}}, 1'b0};

    logic [TIMEOUT_W-1:0] cnt_q;

    always_ff @(posedge clk) begin
        if (rst || clr_i)
            cnt_q <= '0;
        else if (en_i && cnt_q != '1)
            cnt_q <= cnt_q + 1'b1;
    end

    // Fires on the (2**W-1)th idle strobe cycle, i.e. as the count reaches all-ones.
    assign expired_o = en_i && (cnt_q == LAST);
endmodule

// File: rtl/dbg_bus_master.sv
// Debug bus initiator: byte commands from UART RX become single 16-bit bus
// transactions; responses go back out as bytes to UART TX.
module dbg_bus_master
    import dbg_bus_pkg::*;
#(
    parameter int TIMEOUT_W = 10
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  rx_data,
    input  logic        rx_valid,
    output logic        rx_ready,
    output logic [7:0]  tx_data,
    output logic        tx_valid,
    input  logic        tx_ready,
    output logic [7:0]  dbg_a,
    output logic [15:0] dbg_di,
    input  logic [15:0] dbg_do,
    output logic        dbg_we,
    output logic        dbg_rd,
    input  logic        dbg_ready,
    output logic        busy,
    output logic        timeout
);
    state_t      state_q;
    logic        is_wr_q, rd_ok_q;
    logic [7:0]  rd_lo_q, dbg_a_q, tx_data_q;
    logic [15:0] dbg_di_q;
    logic        we_q, rd_q, tx_valid_q, timeout_q;
    logic        expired;

    dbg_bus_wdog #(.TIMEOUT_W(TIMEOUT_W)) u_wdog (
        .clk       (clk),
        .rst       (rst),
        .clr_i     (state_q != S_BUS),
        .en_i      ((state_q == S_BUS) && !dbg_ready),
        .expired_o (expired)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_IDLE;
            is_wr_q    <= 1'b0;
            rd_ok_q    <= 1'b0;
            rd_lo_q    <= 8'h00;
            dbg_a_q    <= 8'h00;
            dbg_di_q   <= 16'h0000;
            we_q       <= 1'b0;
            rd_q       <= 1'b0;
            tx_data_q  <= 8'h00;
            tx_valid_q <= 1'b0;
            timeout_q  <= 1'b0;
        end else begin
            timeout_q <= 1'b0;
            case (state_q)
                S_IDLE: if (rx_valid) begin
                    if (rx_data == OP_WRITE || rx_data == OP_READ) begin
                        is_wr_q <= (rx_data == OP_WRITE);
                        state_q <= S_ADDR;
                    end else begin
                        rd_ok_q    <= 1'b0;
                        tx_data_q  <= RSP_NAK;
                        tx_valid_q <= 1'b1;
                        state_q    <= S_RSP1;
                    end
                end
                S_ADDR: if (rx_valid) begin
                    dbg_a_q <= rx_data;
                    if (is_wr_q) begin
                        state_q <= S_DHI;
                    end else begin
                        rd_q    <= 1'b1;
                        state_q <= S_BUS;
                    end
                end
                S_DHI: if (rx_valid) begin
                    dbg_di_q[15:8] <= rx_data;
                    state_q        <= S_DLO;
                end
                S_DLO: if (rx_valid) begin
                    dbg_di_q[7:0] <= rx_data;
                    we_q          <= 1'b1;
                    state_q       <= S_BUS;
                end
                S_BUS: begin
                    // Ready on the expiry cycle still counts as a normal completion.
                    if (dbg_ready) begin
                        we_q       <= 1'b0;
                        rd_q       <= 1'b0;
                        rd_ok_q    <= !is_wr_q;
                        rd_lo_q    <= dbg_do[7:0];
                        tx_data_q  <= is_wr_q ? RSP_ACK : dbg_do[15:8];
                        tx_valid_q <= 1'b1;
                        state_q    <= S_RSP1;
                    end else if (expired) begin
                        we_q       <= 1'b0;
                        rd_q       <= 1'b0;
                        rd_ok_q    <= 1'b0;
                        timeout_q  <= 1'b1;
                        tx_data_q  <= RSP_ERR;
                        tx_valid_q <= 1'b1;
                        state_q    <= S_RSP1;
                    end
                end
                S_RSP1: if (tx_ready) begin
                    if (rd_ok_q) begin
                        tx_data_q <= rd_lo_q;
                        state_q   <= S_RSP2;
                    end else begin
                        tx_valid_q <= 1'b0;
                        state_q    <= S_IDLE;
                    end
                end
                S_RSP2: if (tx_ready) begin
                    tx_valid_q <= 1'b0;
                    state_q    <= S_IDLE;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign rx_ready = !rst && (state_q == S_IDLE || state_q == S_ADDR ||
                               state_q == S_DHI  || state_q == S_DLO);
    assign busy     = (state_q != S_IDLE);
    assign tx_data  = tx_data_q;
    assign tx_valid = tx_valid_q;
    assign dbg_a    = dbg_a_q;
    assign dbg_di   = dbg_di_q;
    assign dbg_we   = we_q;
    assign dbg_rd   = rd_q;
    assign timeout  = timeout_q;
endmodule

// File: tb/tb_dbg_bus_master.sv
// Random command stream against a transaction-level model of the debug bus master.
module tb_dbg_bus_master;
    localparam int TW   = 10;
    localparam int MAXC = (1 << TW) - 1;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [7:0]  rx_data = 8'h00;
    logic        rx_valid = 1'b0;
    logic        rx_ready;
    logic [7:0]  tx_data;
    logic        tx_valid;
    logic        tx_ready = 1'b0;
    logic [7:0]  dbg_a;
    logic [15:0] dbg_di;
    logic [15:0] dbg_do = 16'h0000;
    logic        dbg_we, dbg_rd;
    logic        dbg_ready = 1'b0;
    logic        busy, timeout;

    always #5 clk = ~clk;

    dbg_bus_master #(.TIMEOUT_W(TW)) dut (
        .clk(clk), .rst(rst),
        .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
        .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
        .dbg_a(dbg_a), .dbg_di(dbg_di), .dbg_do(dbg_do),
        .dbg_we(dbg_we), .dbg_rd(dbg_rd), .dbg_ready(dbg_ready),
        .busy(busy), .timeout(timeout)
    );

    typedef struct packed {
        logic [7:0]  a;
        logic [15:0] d;
        logic        wr;
        logic [15:0] len;
        logic        to;
    } bus_t;

    bus_t        exp_bus[$];
    logic [7:0]  exp_tx[$];
    logic [7:0]  got_tx[$];
    int          n_chk = 0, n_fail = 0;
    int          rsp_delay = 0;
    logic [15:0] rsp_data = 16'h0000;
    int          tx_hold = 0;
    bit          bp_arm = 0;
    int          last_len = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Responder, TX sink and per-cycle checker.
    bit         in_stb = 0, prev_stall = 0;
    int         scnt = 0, stb_len = 0;
    logic [7:0] stb_a, prev_data;
    logic [15:0] stb_d;
    logic       stb_wr;

    always @(negedge clk) begin : monitor
        bit   stb, fell, exp_to;
        bus_t e;
        if (rst) begin
            in_stb = 0; prev_stall = 0; scnt = 0;
            dbg_ready = 1'b0; dbg_do = 16'h0000; tx_ready = 1'b0;
        end else begin
            if (bp_arm && tx_valid) begin tx_hold = 10; bp_arm = 0; end
            if (tx_hold > 0) begin tx_ready = 1'b0; tx_hold--; end
            else tx_ready = ($urandom_range(0, 3) != 0);

            stb    = dbg_we || dbg_rd;
            dbg_do = 16'($urandom);
            if (stb) begin
                dbg_ready = (scnt == rsp_delay);
                if (dbg_ready) dbg_do = rsp_data;
                scnt++;
            end else begin
                dbg_ready = 1'($urandom_range(0, 1));
                scnt = 0;
            end

            chk("we_rd_exclusive", {31'd0, dbg_we & dbg_rd}, 0);
            if (stb || tx_valid) begin
                chk("rx_ready_blocked", {31'd0, rx_ready}, 0);
                chk("busy_active", {31'd0, busy}, 1);
            end
            if (prev_stall) begin
                chk("tx_valid_held", {31'd0, tx_valid}, 1);
                chk("tx_data_held", {24'd0, tx_data}, {24'd0, prev_data});
            end

            fell   = in_stb && !stb;
            exp_to = 0;
            if (stb && !in_stb) begin
                stb_a = dbg_a; stb_d = dbg_di; stb_wr = dbg_we; stb_len = 1;
            end else if (stb) begin
                chk("bus_addr_stable", {24'd0, dbg_a}, {24'd0, stb_a});
                chk("bus_data_stable", {16'd0, dbg_di}, {16'd0, stb_d});
                chk("bus_kind_stable", {31'd0, dbg_we}, {31'd0, stb_wr});
                stb_len++;
            end
            if (fell) begin
                if (exp_bus.size() == 0) chk("bus_unexpected", 1, 0);
                else begin
                    e = exp_bus.pop_front();
                    chk("bus_addr", {24'd0, stb_a}, {24'd0, e.a});
                    chk("bus_is_write", {31'd0, stb_wr}, {31'd0, e.wr});
                    if (e.wr) chk("bus_wdata", {16'd0, stb_d}, {16'd0, e.d});
                    chk("bus_strobe_len", stb_len, {16'd0, e.len});
                    exp_to   = e.to;
                    last_len = stb_len;
                end
            end
            chk("timeout_pulse", {31'd0, timeout}, {31'd0, exp_to});

            if (tx_valid && tx_ready) begin
                got_tx.push_back(tx_data);
                if (exp_tx.size() == 0) chk("tx_unexpected", {24'd0, tx_data}, 32'h100);
                else chk("tx_byte", {24'd0, tx_data}, {24'd0, exp_tx.pop_front()});
            end
            prev_stall = tx_valid && !tx_ready;
            prev_data  = tx_data;
            in_stb     = stb;
        end
    end

    task automatic send_byte(input logic [7:0] b);
        int n = 0;
        repeat ($urandom_range(0, 2)) @(negedge clk);
        rx_data  = b;
        rx_valid = 1'b1;
        while (!rx_ready && n < 3000) begin @(negedge clk); n++; end
        if (!rx_ready) chk("rx_accept_bound", 0, 1);
        @(negedge clk);
        rx_valid = 1'b0;
        rx_data  = 8'($urandom);
    endtask

    // Model: expected bus transaction and response bytes from opcode and responder delay.
    task automatic do_cmd(input logic [7:0] op, input logic [7:0] a, input logic [15:0] d,
                          input int delay, input logic [15:0] rdata, output int lat);
        bit to;
        int n;
        bus_t e;
        rsp_delay = delay;
        rsp_data  = rdata;
        to        = (delay + 1 > MAXC);
        e.a = a; e.d = d; e.wr = (op == 8'h01); e.to = to;
        e.len = 16'(to ? MAXC : delay + 1);
        if (op == 8'h01) begin
            exp_bus.push_back(e);
            exp_tx.push_back(to ? 8'hEE : 8'hA5);
            send_byte(op); send_byte(a); send_byte(d[15:8]); send_byte(d[7:0]);
        end else if (op == 8'h02) begin
            exp_bus.push_back(e);
            if (to) exp_tx.push_back(8'hEE);
            else begin exp_tx.push_back(rdata[15:8]); exp_tx.push_back(rdata[7:0]); end
            send_byte(op); send_byte(a);
        end else begin
            exp_tx.push_back(8'h3F);
            send_byte(op);
        end
        lat = 0;
        while (!tx_valid && lat < 3000) begin @(negedge clk); lat++; end
        n = 0;
        while ((exp_tx.size() != 0 || busy) && n < 5000) begin @(negedge clk); n++; end
        if (n >= 5000) chk("cmd_done_bound", 0, 1);
        chk("bus_all_seen", exp_bus.size(), 0);
    endtask

    function automatic logic [7:0] last_got(input int k);
        return (got_tx.size() > k) ? got_tx[got_tx.size() - 1 - k] : 8'hxx;
    endfunction

    initial begin
        int lat, sz;
        logic [7:0] op;
        repeat (2) @(negedge clk);
        chk("rst_dbg_a", {24'd0, dbg_a}, 0);
        chk("rst_dbg_di", {16'd0, dbg_di}, 0);
        chk("rst_tx_data", {24'd0, tx_data}, 0);
        chk("rst_outputs", {25'd0, tx_valid, dbg_we, dbg_rd, busy, timeout, rx_ready, 1'b0}, 0);
        rst = 1'b0;
        @(negedge clk);

        do_cmd(8'h01, 8'h1B, 16'h1234, 3, 16'h0000, lat);
        chk("t1_we_len", last_len, 4);
        chk("t1_ack", {24'd0, last_got(0)}, 32'hA5);
        chk("t1_addr_kept", {24'd0, dbg_a}, 32'h1B);
        chk("t1_data_kept", {16'd0, dbg_di}, 32'h1234);

        do_cmd(8'h02, 8'h10, 16'h0000, 1, 16'hBEEF, lat);
        chk("t2_rd_len", last_len, 2);
        chk("t2_hi", {24'd0, last_got(1)}, 32'hBE);
        chk("t2_lo", {24'd0, last_got(0)}, 32'hEF);

        sz = got_tx.size();
        do_cmd(8'h02, 8'h05, 16'h0000, 5000, 16'h1111, lat);
        chk("t3_rd_len", last_len, 1023);
        chk("t3_err_only", got_tx.size() - sz, 1);
        chk("t3_err", {24'd0, last_got(0)}, 32'hEE);
        do_cmd(8'h02, 8'h10, 16'h0000, 0, 16'hBEEF, lat);
        chk("t3_recover", {24'd0, last_got(0)}, 32'hEF);

        do_cmd(8'h01, 8'h22, 16'hA0A1, MAXC - 1, 16'h0000, lat);
        chk("edge_ready_wins", {24'd0, last_got(0)}, 32'hA5);
        chk("edge_len", last_len, 1023);

        do_cmd(8'h7F, 8'h00, 16'h0000, 0, 16'h0000, lat);
        chk("t4_nak", {24'd0, last_got(0)}, 32'h3F);
        chk("t4_idle", {31'd0, busy}, 0);

        bp_arm = 1;
        do_cmd(8'h02, 8'h44, 16'h0000, 2, 16'hBEEF, lat);
        chk("t5_hi", {24'd0, last_got(1)}, 32'hBE);
        chk("t5_lo", {24'd0, last_got(0)}, 32'hEF);

        do_cmd(8'h01, 8'h30, 16'h5A5A, 0, 16'h0000, lat);
        chk("latency_cycles", lat + 1, 2);

        rsp_delay = 5000;
        send_byte(8'h02); send_byte(8'h33);
        chk("t6_rd_active", {31'd0, dbg_rd}, 1);
        repeat (3) @(negedge clk);
        rst = 1'b1;
        exp_bus.delete(); exp_tx.delete();
        @(negedge clk);
        chk("t6_rst_rd", {31'd0, dbg_rd}, 0);
        chk("t6_rst_txv", {31'd0, tx_valid}, 0);
        chk("t6_rst_busy", {31'd0, busy}, 0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        do_cmd(8'h01, 8'h1A, 16'h0007, 2, 16'h0000, lat);
        chk("t6_ack", {24'd0, last_got(0)}, 32'hA5);

        for (int i = 0; i < 30; i++) begin
            int sel, dly;
            sel = $urandom_range(0, 9);
            dly = ($urandom_range(0, 19) == 0) ? $urandom_range(MAXC - 3, MAXC + 3)
                                               : $urandom_range(0, 5);
            if (sel < 4) op = 8'h01;
            else if (sel < 8) op = 8'h02;
            else begin
                op = 8'($urandom);
                if (op == 8'h01 || op == 8'h02) op = 8'hFF;
            end
            if ($urandom_range(0, 4) == 0) bp_arm = 1;
            do_cmd(op, 8'($urandom), 16'($urandom), dly, 16'($urandom), lat);
        end

        repeat (5) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
